ecc_enc_serializer: RTL and testbench
=====================================

Name: ecc_enc_serializer

Overview:
Encodes a 32-bit data word into a 38-bit SEC codeword (6 parity + 32 data) for the NVM programming path, then shifts the codeword out serially to the array write driver.
- Each bit is held for a programmable number of clock cycles; downstream can stall the shift.
- The codeword matches the format consumed by the on-chip ECC decoder: codeword[37:32] = p[5:0], codeword[31:0] = data.

Parameters:
BIT_CYC, 4, clock cycles each serial bit is held (legal range 1..255)
CNT_W, 8, width of the per-bit cycle counter (must hold BIT_CYC-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
din  in  32  data word to encode
din_vld  in  1  din valid
din_rdy  out  1  encoder can accept a word
abort  in  1  synchronous abort of the current transfer
ser_rdy  in  1  downstream accepts/advances the serial bit
ser_dat  out  1  serial codeword bit, MSB (bit 37) first
ser_vld  out  1  ser_dat valid
ser_last  out  1  current bit is codeword bit 0
done  out  1  one-cycle pulse after the last bit completes
cw  out  38  registered codeword of the most recently accepted word

Behaviour:
Decided interface: one clock (clk); reset is asynchronous and active-low (rst_n).

Parity (combinational from din, registered on accept); d = din; ^ = XOR:
- p5 = ^{d31,d30,d29,d28,d27,d16,d15,d14,d13,d12,d11,d10,d9}
- p4 = ~^{d31,d26,d25,d24,d23,d16,d15,d14,d8,d7,d6,d5,d4,d3}
- p3 = ^{d30,d26,d22,d21,d20,d13,d12,d8,d7,d6,d2,d1,d0}
- p2 = ~^{d29,d25,d22,d19,d18,d16,d13,d11,d10,d8,d5,d4,d2,d1}
- p1 = ^{d28,d24,d21,d19,d17,d15,d11,d9,d7,d5,d3,d2,d0}
- p0 = ~^{d27,d23,d20,d18,d17,d14,d12,d10,d9,d6,d4,d3,d1,d0}

Reset values:
- state = IDLE.
- cw, shift register, bit_cnt, cyc_cnt, ser_dat, ser_vld, ser_last and done all 0.
- din_rdy = (state==IDLE), so it reads 1 while reset is held.

FSM:
- IDLE: din_rdy=1. On din_vld, load cw and the shift register with {p,din}, set bit_cnt=37 and cyc_cnt=BIT_CYC-1, go to SHIFT. ser_vld rises on the next cycle (1-cycle latency). No accept happens while abort=1; abort wins.
- SHIFT: din_rdy=0, ser_vld=1, ser_dat=sreg[37], ser_last=(bit_cnt==0).
  - cyc_cnt decrements only on cycles with ser_rdy=1; ser_rdy=0 freezes all counters and the data.
  - When cyc_cnt==0 and ser_rdy=1:
    - if bit_cnt==0, go to DONE;
    - otherwise shift sreg left by 1, decrement bit_cnt, reload cyc_cnt=BIT_CYC-1.
- DONE: done=1 for exactly one cycle, ser_vld=0, din_rdy=0, then go to IDLE.

Throughput and edge cases:
- Minimum accept-to-accept spacing is 38*BIT_CYC+2 cycles.
- abort=1 in SHIFT or DONE: go to IDLE next cycle, ser_vld/ser_last/done forced 0, no done pulse. cw is retained.
- abort and the final ser_rdy in the same cycle: abort wins, no done pulse.
- BIT_CYC=1: one bit per ser_rdy=1 cycle; cyc_cnt stays 0.
- cw changes only on accept.
- rst_n asserted mid-transfer: immediate return to reset values; the transfer is lost.

Optional Feature:
Macro ECC_ENC_ERR_INJ_EN.
- Defined: adds input port inj_mask[37:0]. On accept, the loaded codeword is {p,din} ^ inj_mask; both cw and the serial stream carry the corrupted value. Used to exercise the decoder's single-bit correction.
- Undefined: the port is absent and the codeword is unmodified.

Test Plan:
- din=32'h00000000, ser_rdy=1, BIT_CYC=4 -> cw=38'h15_0000_0000; 152 ser_vld cycles; ser_dat stream 010101 followed by 32 zeros; done pulses 1 cycle later.
- din=32'hFFFFFFFF -> cw=38'h3F_FFFF_FFFF. din=32'h80000000 -> cw=38'h25_8000_0000.
- ser_rdy toggled 1/0 every cycle, BIT_CYC=2 -> each bit held 4 cycles; total 152 ser_vld cycles; ser_last high only during the final 4.
- abort asserted on the 10th SHIFT cycle -> ser_vld=0 next cycle, no done, din_rdy=1; next word din=32'h80000000 streams with cw=38'h25_8000_0000.
- rst_n pulled low mid-SHIFT -> all outputs 0 asynchronously, din_rdy=1; after release a new word encodes correctly.
- ECC_ENC_ERR_INJ_EN with inj_mask=38'h1, din=0 -> cw=38'h15_0000_0001; the on-chip decoder output returns 32'h00000000.

Source files
------------

// File: rtl/ecc_enc_serializer.sv
// SEC encoder (6 parity + 32 data) with a stallable, bit-hold serializer, MSB first.
// Optional macro ECC_ENC_ERR_INJ_EN adds inj_mask to corrupt the loaded codeword.
module ecc_enc_serializer #(
  parameter int unsigned BIT_CYC = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] din,
  input  logic        din_vld,
  output logic        din_rdy,
  input  logic        abort,
  input  logic        ser_rdy,
  output logic        ser_dat,
  output logic        ser_vld,
  output logic        ser_last,
  output logic        done,
`ifdef ECC_ENC_ERR_INJ_EN
  input  logic [37:0] inj_mask,
`endif
  output logic [37:0] cw
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CYC_RELOAD = CNT_W'(BIT_CYC - 1);
  localparam logic [5:0]       FIRST_BIT  = 6'd37;

  state_t           state_q,   state_d;
  logic [37:0]      cw_q,      cw_d;
  logic [37:0]      sreg_q,    sreg_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic             ser_dat_q, ser_dat_d;
  logic             ser_vld_q, ser_vld_d;
  logic             ser_last_q, ser_last_d;
  logic             done_q,    done_d;

  logic [5:0]       parity;
  logic [37:0]      cw_new;

  // Odd-indexed parity bits are plain XOR, even-indexed are XNOR; the decoder relies on this.
  always_comb begin
    parity[5] =  ^{din[31], din[30], din[29], din[28], din[27], din[16], din[15],
                   din[14], din[13], din[12], din[11], din[10], din[9]};
    parity[4] = ~^{din[31], din[26], din[25], din[24], din[23], din[16], din[15],
                   din[14], din[8],  din[7],  din[6],  din[5],  din[4],  din[3]};
    parity[3] =  ^{din[30], din[26], din[22], din[21], din[20], din[13], din[12],
                   din[8],  din[7],  din[6],  din[2],  din[1],  din[0]};
    parity[2] = ~^{din[29], din[25], din[22], din[19], din[18], din[16], din[13],
                   din[11], din[10], din[8],  din[5],  din[4],  din[2],  din[1]};
    parity[1] =  ^{din[28], din[24], din[21], din[19], din[17], din[15], din[11],
                   din[9],  din[7],  din[5],  din[3],  din[2],  din[0]};
    parity[0] = ~^{din[27], din[23], din[20], din[18], din[17], din[14], din[12],
                   din[10], din[9],  din[6],  din[4],  din[3],  din[1],  din[0]};
  end

`ifdef ECC_ENC_ERR_INJ_EN
  assign cw_new = {parity, din} ^ inj_mask;
`else
  assign cw_new = {parity, din};
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    cw_d      = cw_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    ser_vld_d = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort blocks acceptance so a stray word cannot start during cancellation
        if (din_vld && !abort) begin
          cw_d      = cw_new;
          sreg_d    = cw_new;
          bit_cnt_d = FIRST_BIT;
          cyc_cnt_d = CYC_RELOAD;
          ser_vld_d = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        ser_vld_d = 1'b1;
        if (abort) begin
          ser_vld_d = 1'b0;
          state_d   = IDLE;
        end else if (ser_rdy) begin
          if (cyc_cnt_q != '0) begin
            cyc_cnt_d = cyc_cnt_q - 1'b1;
          end else if (bit_cnt_q == '0) begin
            ser_vld_d = 1'b0;
            done_d    = 1'b1;
            state_d   = DONE;
          end else begin
            sreg_d    = {sreg_q[36:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 1'b1;
            cyc_cnt_d = CYC_RELOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from next-state values so they line up with the state flops.
    ser_dat_d  = ser_vld_d & sreg_d[37];
    ser_last_d = ser_vld_d & (bit_cnt_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cw_q       <= '0;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      ser_dat_q  <= 1'b0;
      ser_vld_q  <= 1'b0;
      ser_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cw_q       <= cw_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      ser_dat_q  <= ser_dat_d;
      ser_vld_q  <= ser_vld_d;
      ser_last_q <= ser_last_d;
      done_q     <= done_d;
    end
  end

  assign din_rdy  = (state_q == IDLE);
  assign ser_dat  = ser_dat_q;
  assign ser_vld  = ser_vld_q;
  assign ser_last = ser_last_q;
  assign done     = done_q;
  assign cw       = cw_q;

endmodule

// File: tb/tb_ecc_enc_serializer.sv
// Randomised self-checking bench for ecc_enc_serializer against a transaction-level model
// that tracks progress as a count of accepted ser_rdy cycles.
module tb_ecc_enc_serializer;

  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        din_vld = 1'b0;
  logic        din_rdy;
  logic        abort = 1'b0;
  logic        ser_rdy = 1'b1;
  logic        ser_dat, ser_vld, ser_last, done;
  logic [37:0] cw;
`ifdef ECC_ENC_ERR_INJ_EN
  logic [37:0] inj_mask = '0;
`endif

  ecc_enc_serializer #(.BIT_CYC(BC), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .abort    (abort),
    .ser_rdy  (ser_rdy),
    .ser_dat  (ser_dat),
    .ser_vld  (ser_vld),
    .ser_last (ser_last),
    .done     (done),
`ifdef ECC_ENC_ERR_INJ_EN
    .inj_mask (inj_mask),
`endif
    .cw       (cw)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Parity coverage expressed as index lists; even-numbered parity bits are inverted.
  logic [31:0] pmask [6];
  initial begin
    int l5[$] = '{31,30,29,28,27,16,15,14,13,12,11,10,9};
    int l4[$] = '{31,26,25,24,23,16,15,14,8,7,6,5,4,3};
    int l3[$] = '{30,26,22,21,20,13,12,8,7,6,2,1,0};
    int l2[$] = '{29,25,22,19,18,16,13,11,10,8,5,4,2,1};
    int l1[$] = '{28,24,21,19,17,15,11,9,7,5,3,2,0};
    int l0[$] = '{27,23,20,18,17,14,12,10,9,6,4,3,1,0};
    for (int j = 0; j < 6; j++) pmask[j] = '0;
    foreach (l5[i]) pmask[5][l5[i]] = 1'b1;
    foreach (l4[i]) pmask[4][l4[i]] = 1'b1;
    foreach (l3[i]) pmask[3][l3[i]] = 1'b1;
    foreach (l2[i]) pmask[2][l2[i]] = 1'b1;
    foreach (l1[i]) pmask[1][l1[i]] = 1'b1;
    foreach (l0[i]) pmask[0][l0[i]] = 1'b1;
  end

  function automatic logic [37:0] enc(input logic [31:0] d);
    logic [5:0] p;
    for (int j = 0; j < 6; j++) p[j] = (^(d & pmask[j])) ^ (j % 2 == 0);
    return {p, d};
  endfunction

  // Model: busy with k ser_rdy cycles consumed; bit shown is codeword[37 - k/BC].
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [37:0] m_cw   = '0;
  int          m_k    = 0;
  int          n_vld = 0, n_last = 0, n_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_cw = '0; m_k = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      if (abort) m_busy = 1'b0;
      else if (ser_rdy) begin
        m_k++;
        if (m_k == 38 * BC) begin m_busy = 1'b0; m_done = 1'b1; end
      end
    end else if (din_vld && !abort) begin
`ifdef ECC_ENC_ERR_INJ_EN
      m_cw = enc(din) ^ inj_mask;
`else
      m_cw = enc(din);
`endif
      m_busy = 1'b1; m_k = 0;
    end
    #1;
    check("ser_vld", 64'(ser_vld), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("din_rdy", 64'(din_rdy), 64'(!m_busy && !m_done));
    check("ser_last", 64'(ser_last), 64'(m_busy && (m_k / BC == 37)));
    check("cw", 64'(cw), 64'(m_cw));
    if (m_busy) check("ser_dat", 64'(ser_dat), 64'(m_cw[37 - m_k / BC]));
    if (ser_vld) n_vld++;
    if (ser_last) n_last++;
    if (done) n_done++;
  end

  // ser_rdy pattern: 0 = held high, 1 = toggle every cycle, 2 = random ~75% high
  int rdy_mode = 0;
  always @(negedge clk) begin
    case (rdy_mode)
      1:       ser_rdy = ~ser_rdy;
      2:       ser_rdy = ($urandom_range(3) != 0);
      default: ser_rdy = 1'b1;
    endcase
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (din_rdy) break;
    end
    if (i == 2000) check("wait_idle_timeout", 64'(din_rdy), 64'd1);
  endtask

  task automatic send(input logic [31:0] d);
    wait_idle();
    n_vld = 0; n_last = 0;
    din = d; din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 2000) check("wait_done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int d0;
    // Reset state
    #3;
    check("rst_din_rdy", 64'(din_rdy), 64'd1);
    check("rst_ser_vld", 64'(ser_vld), 64'd0);
    check("rst_cw", 64'(cw), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Model pins
    check("model_enc_0", 64'(enc(32'h0000_0000)), 64'(38'h15_0000_0000));
    check("model_enc_f", 64'(enc(32'hFFFF_FFFF)), 64'(38'h3F_FFFF_FFFF));
    check("model_enc_8", 64'(enc(32'h8000_0000)), 64'(38'h25_8000_0000));

    // All-zero word, continuous ser_rdy
    send(32'h0000_0000);
    check("zero_cw", 64'(cw), 64'(38'h15_0000_0000));
    wait_done();
    check("zero_vld_cycles", 64'(n_vld), 64'(38 * BC));
    check("zero_last_cycles", 64'(n_last), 64'(BC));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    send(32'hFFFF_FFFF);
    check("ones_cw", 64'(cw), 64'(38'h3F_FFFF_FFFF));
    wait_done();
    send(32'h8000_0000);
    check("msb_cw", 64'(cw), 64'(38'h25_8000_0000));
    wait_done();

    // Toggling ser_rdy doubles hold time
    rdy_mode = 1;
    send($urandom);
    wait_done();
    check("toggle_vld_cycles", 64'(n_vld), 64'(2 * 38 * BC));
    check("toggle_last_cycles", 64'(n_last), 64'(2 * BC));
    rdy_mode = 0;

    // Abort on the 10th shift cycle
    send(32'h1234_5678);
    repeat (9) @(negedge clk);
    d0 = n_done;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_vld", 64'(ser_vld), 64'd0);
    check("abort_rdy", 64'(din_rdy), 64'd1);
    check("abort_cw_kept", 64'(cw), 64'(enc(32'h1234_5678)));
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(n_done), 64'(d0));
    send(32'h8000_0000);
    check("post_abort_cw", 64'(cw), 64'(38'h25_8000_0000));
    wait_done();

    // Asynchronous reset mid-transfer
    send(32'hCAFE_F00D);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld", 64'(ser_vld), 64'd0);
    check("arst_rdy", 64'(din_rdy), 64'd1);
    check("arst_cw", 64'(cw), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h0000_0000);
    check("post_rst_cw", 64'(cw), 64'(38'h15_0000_0000));
    wait_done();

`ifdef ECC_ENC_ERR_INJ_EN
    inj_mask = 38'h1;
    send(32'h0000_0000);
    check("inj_cw", 64'(cw), 64'(38'h15_0000_0001));
    wait_done();
    inj_mask = '0;
`endif

    // Random traffic with stalls and rare aborts
    rdy_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      din     = $urandom;
      din_vld = ($urandom_range(2) == 0);
      abort   = ($urandom_range(399) == 0);
    end
    din_vld = 1'b0; abort = 1'b0; rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
